// File: rtl/d_fifo_reader_pkg.sv
// Shared definitions for the egress FIFO reader: state encodings, source IDs
// and the default word width.
// Purely declarative; no logic.
package d_fifo_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  typedef enum logic {
    SRC_D0 = 1'b0,
    SRC_D1 = 1'b1
  } src_t;

endpackage

// File: rtl/d_fifo_reader_out_buffer_2.sv
// Purpose: 2-entry FIFO of {src, data} holding words returned from the egress FIFOs.
// Latency: a push is visible at the head the following cycle.
// Backpressure: none internally; the caller guarantees it never pushes when full.
module out_buffer_2 #(
  parameter int DATA_WIDTH = d_fifo_reader_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  push_src,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  head_src,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_data [2];
  logic                  mem_src  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_src[0]  <= 1'b0;
      mem_src[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_src[wr_ptr]  <= push_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem_data[rd_ptr];
  assign head_src  = mem_src[rd_ptr];

endmodule

// File: rtl/d_fifo_reader.sv
// Purpose: round-robin pops of egress FIFOs D0/D1, merged into one tagged valid/ready stream.
// Latency: 2 cycles from a pop to valid_out (1 FIFO read latency + 1 buffer write).
// Backpressure: ready_in low stops new pops once buffered plus in-flight words reach 2.
module d_fifo_reader
  import d_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   empty_fifo_D0,
  input  logic                   empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0]  data_out_D0,
  input  logic [DATA_WIDTH-1:0]  data_out_D1,
  input  logic                   ready_in,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   src_out,
  output logic [COUNT_WIDTH-1:0] count_D0,
  output logic [COUNT_WIDTH-1:0] count_D1,
  output logic [1:0]             state_out
);

  logic [1:0] buf_count;
  logic       inflight;
  logic       inflight_src;
  logic       last;
  logic       deq;
  logic [2:0] occ;
  logic       pick_d1;
  logic       can_pop;
  logic       issue;
  logic       push_src;
  logic [DATA_WIDTH-1:0] push_data;
  state_t     state;
  state_t     state_next;

  assign valid_out = (buf_count != 2'd0);
  assign deq       = valid_out && ready_in;
  // Slots already committed: held words plus the one returning, minus the one leaving now.
  assign occ       = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, deq};

  // Returning FIFO data is captured using the source tag registered with the pop.
  assign push_src  = inflight_src;
  assign push_data = inflight_src ? data_out_D1 : data_out_D0;

  out_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_src  (push_src),
    .push_data (push_data),
    .pop       (deq),
    .count     (buf_count),
    .head_src  (src_out),
    .head_data (data_out)
  );

  // Round-robin choice and pop eligibility; at most one pop per cycle.
  always_comb begin
    pick_d1 = 1'b0;
    can_pop = 1'b0;
    if (!empty_fifo_D0 && !empty_fifo_D1) begin
      pick_d1 = (last == SRC_D0);
      can_pop = 1'b1;
    end else if (!empty_fifo_D0) begin
      pick_d1 = 1'b0;
      can_pop = 1'b1;
    end else if (!empty_fifo_D1) begin
      pick_d1 = 1'b1;
      can_pop = 1'b1;
    end
    issue  = !reset && enable && (occ < 3'd2) && can_pop;
    D0_pop = issue && !pick_d1;
    D1_pop = issue && pick_d1;
  end

  // In-flight tracking and the round-robin pointer, which moves only on a real pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_src <= SRC_D0;
      last         <= SRC_D1;
    end else begin
      inflight     <= D0_pop || D1_pop;
      inflight_src <= D1_pop;
      if (D0_pop) last <= SRC_D0;
      if (D1_pop) last <= SRC_D1;
    end
  end

  // Delivered-word counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_D0 <= '0;
      count_D1 <= '0;
    end else if (deq) begin
      if (src_out == SRC_D0) begin
        if (count_D0 != '1) count_D0 <= count_D0 + 1'b1;
      end else begin
        if (count_D1 != '1) count_D1 <= count_D1 + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state from the current cycle's activity.
  always_comb begin
    state_next = ST_ACTIVE;
    if ((buf_count == 2'd0) && !inflight && !(D0_pop || D1_pop)) begin
      state_next = ST_IDLE;
    end else if ((buf_count == 2'd2) && !ready_in) begin
      state_next = ST_STALL;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_d_fifo_reader.sv
// Scoreboarded bench: egress FIFO models feed the reader, expected words are
// queued at load time and a forked monitor compares every accepted output word.
module tb_d_fifo_reader;
  import d_fifo_reader_pkg::*;

  localparam int DW = 6;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, ready_in;
  logic          empty_fifo_D0, empty_fifo_D1;
  logic [DW-1:0] data_out_D0, data_out_D1, data_out;
  logic          D0_pop, D1_pop, valid_out, src_out;
  logic [CW-1:0] count_D0, count_D1;
  logic [1:0]    state_out;

  d_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .ready_in(ready_in), .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .count_D0(count_D0), .count_D1(count_D1), .state_out(state_out)
  );

  // Egress FIFO models: words appended by the stimulus, read one cycle after a pop.
  logic [DW-1:0] d0_mem [0:1023];
  logic [DW-1:0] d1_mem [0:1023];
  int d0_wr = 0, d0_rd = 0, d1_wr = 0, d1_rd = 0;
  logic fifo_flush = 1'b0;
  assign empty_fifo_D0 = (d0_wr == d0_rd);
  assign empty_fifo_D1 = (d1_wr == d1_rd);

  always @(posedge clk) begin
    if (fifo_flush) begin
      d0_rd <= d0_wr;
      d1_rd <= d1_wr;
    end else begin
      if (D0_pop) begin data_out_D0 <= d0_mem[d0_rd]; d0_rd <= d0_rd + 1; end
      if (D1_pop) begin data_out_D1 <= d1_mem[d1_rd]; d1_rd <= d1_rd + 1; end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q [$];
  int   pop_cyc [$];
  logic pop_src [$];
  int   dlv_cyc [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load0(input logic [DW-1:0] w);
    d0_mem[d0_wr] = w;
    d0_wr = d0_wr + 1;
  endtask

  task automatic load1(input logic [DW-1:0] w);
    d1_mem[d1_wr] = w;
    d1_wr = d1_wr + 1;
  endtask

  task automatic expect_word(input logic s, input logic [DW-1:0] w);
    exp_q.push_back({s, w});
  endtask

  task automatic clear_logs();
    exp_q.delete();
    pop_cyc.delete();
    pop_src.delete();
    dlv_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (exp_q.size() == 0 && state_out == ST_IDLE && !valid_out) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  // Monitor: logs pops and compares every accepted word against the scoreboard.
  task automatic monitor();
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (D0_pop) begin pop_cyc.push_back(cyc); pop_src.push_back(1'b0); end
        if (D1_pop) begin pop_cyc.push_back(cyc); pop_src.push_back(1'b1); end
        if (D0_pop && D1_pop) chk("both_pops", 1, 0);
        if (valid_out && ready_in) begin
          dlv_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", int'({src_out, data_out}), -1);
          end else begin
            e = exp_q.pop_front();
            chk("word", int'({src_out, data_out}), int'(e));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [DW-1:0] w;
    // Reset state
    reset = 1'b1; enable = 1'b0; ready_in = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_src", int'(src_out), 0);
    chk("rst_cnt0", int'(count_D0), 0);
    chk("rst_cnt1", int'(count_D1), 0);
    chk("rst_state", int'(state_out), 0);
    chk("rst_pops", int'({D0_pop, D1_pop}), 0);

    // Two D0 words, D1 empty
    clear_logs();
    enable = 1'b1; ready_in = 1'b1;
    load0(6'b000101); load0(6'b000110);
    expect_word(1'b0, 6'b000101); expect_word(1'b0, 6'b000110);
    wait_idle("t1_drain", 20);
    chk("t1_npops", pop_cyc.size(), 2);
    chk("t1_pop_back2back", pop_cyc[1] - pop_cyc[0], 1);
    chk("t1_pop_src", int'({pop_src[0], pop_src[1]}), 0);
    chk("t1_latency", dlv_cyc[0] - pop_cyc[0], 2);
    chk("t1_cnt0", int'(count_D0), 2);

    // Both FIFOs loaded: strict alternation starting with D0
    do_reset();
    load0(6'b000100); load0(6'b000101); load0(6'b000110);
    load1(6'b001110); load1(6'b001111); load1(6'b010000);
    expect_word(1'b0, 6'b000100); expect_word(1'b1, 6'b001110);
    expect_word(1'b0, 6'b000101); expect_word(1'b1, 6'b001111);
    expect_word(1'b0, 6'b000110); expect_word(1'b1, 6'b010000);
    wait_idle("t2_drain", 30);
    chk("t2_npops", pop_cyc.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_pop_order", int'(pop_src[i]), i % 2);
    chk("t2_cnt0", int'(count_D0), 3);
    chk("t2_cnt1", int'(count_D1), 3);

    // Downstream stall: two pops fill the buffer, then resume at one per cycle
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 6'd32 + 6'(i);
      load0(w);
      expect_word(1'b0, w);
    end
    step(6);
    chk("t3_npops_stalled", pop_cyc.size(), 2);
    chk("t3_state_stall", int'(state_out), 2);
    chk("t3_valid", int'(valid_out), 1);
    chk("t3_head", int'(data_out), 32);
    step(3);
    chk("t3_head_stable", int'(data_out), 32);
    chk("t3_npops_still", pop_cyc.size(), 2);
    ready_in = 1'b1;
    wait_idle("t3_drain", 40);
    chk("t3_npops", pop_cyc.size(), 8);
    for (int i = 3; i < 8; i++) chk("t3_pop_rate", pop_cyc[i] - pop_cyc[2], i - 2);
    chk("t3_cnt0", int'(count_D0), 8);

    // Enable dropped the cycle after a pop
    do_reset();
    load0(6'd40); load0(6'd41); load0(6'd42); load0(6'd43);
    expect_word(1'b0, 6'd40);
    step(1);
    enable = 1'b0;
    step(3);
    chk("t4_state_idle", int'(state_out), 0);
    chk("t4_delivered", exp_q.size(), 0);
    step(3);
    chk("t4_npops", pop_cyc.size(), 1);
    chk("t4_cnt0", int'(count_D0), 1);
    fifo_flush = 1'b1;
    step(1);
    fifo_flush = 1'b0;

    // Async reset with a full buffer, then D0 wins first
    clear_logs();
    ready_in = 1'b0; enable = 1'b1;
    load0(6'd50); load0(6'd51); load0(6'd52); load0(6'd53);
    step(5);
    chk("t5_pre_state", int'(state_out), 2);
    chk("t5_pre_cnt0", int'(count_D0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", int'(valid_out), 0);
    chk("t5_async_cnt0", int'(count_D0), 0);
    chk("t5_async_pops", int'({D0_pop, D1_pop}), 0);
    chk("t5_async_state", int'(state_out), 0);
    chk("t5_async_data", int'(data_out), 0);
    @(posedge clk);
    #1;
    clear_logs();
    reset = 1'b0; ready_in = 1'b1;
    load1(6'd20); load1(6'd21);
    expect_word(1'b0, 6'd52); expect_word(1'b1, 6'd20);
    expect_word(1'b0, 6'd53); expect_word(1'b1, 6'd21);
    wait_idle("t5_drain", 30);
    chk("t5_first_grant", int'(pop_src[0]), 0);
    chk("t5_cnt0", int'(count_D0), 2);
    chk("t5_cnt1", int'(count_D1), 2);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      w = 6'(i);
      load1(w);
      expect_word(1'b1, w);
    end
    wait_idle("t6_drain", 700);
    chk("t6_cnt1_sat", int'(count_D1), 255);
    chk("t6_cnt0", int'(count_D0), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2000000;
        chk("global_timeout", 0, 1);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
